// File: rtl/riscv_pkg.sv
// Shared constants and the trace-entry layout for the RISC-V pipeline and its trace tap.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;

  // Store to this word address marks program completion.
  localparam logic [XLEN-1:0] TOHOST_ADDR_DEFAULT = 32'h0000_0100;

  localparam int TRACE_CNT_W = 32;

  typedef struct packed {
    logic [TRACE_CNT_W-1:0] cycle;
    logic [XLEN-1:0]        addr;
    logic [XLEN-1:0]        data;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head output.
// Latency: a push at edge N is visible on head_dat in cycle N+1 when empty.
// Backpressure: full asserts at DEPTH entries; push while full is only honoured
//   together with a pop, which replaces the departing slot.
// Ports: clk/rst, push/push_dat in, pop in, full/empty/head_dat out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_eff) begin
      // When full, this slot is the head being popped on the same edge.
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which slots are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/store_trace_unit.sv
// Timestamps data-memory word stores and queues them for a valid/ready consumer;
//   a store to TOHOST latches the exit code and stops further capture.
// Latency: captured store appears on trace_* one cycle after its strobe edge; flags likewise.
// Backpressure: trace_ready stalls the head; stores arriving while full (no pop) are dropped and counted.
// Ports: clk, rst; mem_write_word_en/mem_addr/mem_write_data tap;
//   trace_valid/trace_ready/trace_cycle/trace_addr/trace_data drain;
//   done, exit_code, overflow, drop_count, misaligned status.
module store_trace_unit
  import riscv_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_write_word_en,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_write_data,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [CNT_W-1:0] trace_cycle,
  output logic [31:0]      trace_addr,
  output logic [31:0]      trace_data,
  output logic             done,
  output logic [31:0]      exit_code,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic             misaligned
);

  localparam int ENTRY_W = CNT_W + 64;

  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               done_q, done_d;
  logic [31:0]        exit_code_q, exit_code_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               misaligned_q, misaligned_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_dat;
  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;

  assign capture = mem_write_word_en && !done_q;
  assign pop     = !fifo_empty && trace_ready;
  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({cycle_cnt_q, mem_addr, mem_write_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
    done_d       = done_q;
    exit_code_d  = exit_code_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    misaligned_d = misaligned_q;
    if (capture) begin
      if (mem_addr[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
      // done is raised even if the TOHOST entry itself is dropped.
      if (mem_addr == TOHOST_ADDR) begin
        done_d      = 1'b1;
        exit_code_d = mem_write_data;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q  <= '0;
      done_q       <= 1'b0;
      exit_code_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      done_q       <= done_d;
      exit_code_q  <= exit_code_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign trace_valid = !fifo_empty;
  assign trace_cycle = fifo_empty ? '0 : head_dat[ENTRY_W-1 -: CNT_W];
  assign trace_addr  = fifo_empty ? '0 : head_dat[63:32];
  assign trace_data  = fifo_empty ? '0 : head_dat[31:0];

  assign done        = done_q;
  assign exit_code   = exit_code_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_store_trace_unit.sv
module tb_store_trace_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write_word_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_cycle;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        done;
  logic [31:0] exit_code;
  logic        overflow;
  logic [15:0] drop_count;
  logic        misaligned;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = '0;
  logic [31:0] ts0;

  always #5 clk = ~clk;

  store_trace_unit #(
    .DEPTH       (16),
    .TOHOST_ADDR (32'h0000_0100),
    .CNT_W       (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_write_word_en (mem_write_word_en),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_cycle       (trace_cycle),
    .trace_addr        (trace_addr),
    .trace_data        (trace_data),
    .done              (done),
    .exit_code         (exit_code),
    .overflow          (overflow),
    .drop_count        (drop_count),
    .misaligned        (misaligned)
  );

  // Advance one edge; exp_cnt tracks the cycle counter value of the new cycle.
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) exp_cnt = '0;
    else   exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write_word_en = 1'b1;
    mem_addr          = a;
    mem_write_data    = d;
  endtask

  task automatic idle();
    mem_write_word_en = 1'b0;
    mem_addr          = '0;
    mem_write_data    = '0;
  endtask

  task automatic check_flags_clear(input string tag);
    check({tag, "_valid"},  64'(trace_valid), 64'd0);
    check({tag, "_done"},   64'(done),        64'd0);
    check({tag, "_exit"},   64'(exit_code),   64'd0);
    check({tag, "_ovf"},    64'(overflow),    64'd0);
    check({tag, "_drops"},  64'(drop_count),  64'd0);
    check({tag, "_misal"},  64'(misaligned),  64'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_flags_clear("reset");

    // Single store at cycle 3
    tick();
    tick();
    tick();
    store(32'h0, 32'd5);
    trace_ready = 1'b1;
    tick();
    idle();
    check("single_valid", 64'(trace_valid), 64'd1);
    check("single_cycle", 64'(trace_cycle), 64'd3);
    check("single_addr",  64'(trace_addr),  64'h0);
    check("single_data",  64'(trace_data),  64'd5);
    check("single_ovf",   64'(overflow),    64'd0);
    tick();
    check("single_popped", 64'(trace_valid), 64'd0);

    // Overflow: 18 stores, consumer stalled
    trace_ready = 1'b0;
    ts0 = exp_cnt;
    for (int i = 0; i < 18; i++) begin
      store(32'h1000 + 32'(4 * i), 32'd100 + 32'(i));
      tick();
    end
    idle();
    check("ovf_flag",  64'(overflow),   64'd1);
    check("ovf_drops", 64'(drop_count), 64'd2);
    check("ovf_misal", 64'(misaligned), 64'd0);
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_valid", 64'(trace_valid), 64'd1);
      check("ovf_drain_cycle", 64'(trace_cycle), 64'(ts0 + 32'(i)));
      check("ovf_drain_addr",  64'(trace_addr),  64'(32'h1000 + 32'(4 * i)));
      check("ovf_drain_data",  64'(trace_data),  64'(32'd100 + 32'(i)));
      tick();
    end
    check("ovf_drained_empty", 64'(trace_valid), 64'd0);

    // Full with simultaneous pop
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      store(32'h2000 + 32'(4 * i), 32'(i));
      tick();
    end
    check("fullpop_no_new_drop", 64'(drop_count), 64'd2);
    ts0 = exp_cnt;
    store(32'h3000, 32'hABCD);
    trace_ready = 1'b1;
    tick();
    idle();
    trace_ready = 1'b0;
    tick();
    check("fullpop_drops", 64'(drop_count), 64'd2);
    trace_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("fullpop_drain_addr", 64'(trace_addr), 64'(32'h2000 + 32'(4 * i)));
      tick();
    end
    check("fullpop_last_valid", 64'(trace_valid), 64'd1);
    check("fullpop_last_addr",  64'(trace_addr),  64'h3000);
    check("fullpop_last_data",  64'(trace_data),  64'hABCD);
    check("fullpop_last_cycle", 64'(trace_cycle), 64'(ts0));
    tick();
    check("fullpop_empty", 64'(trace_valid), 64'd0);

    // Misaligned store
    trace_ready = 1'b0;
    store(32'h6, 32'h77);
    tick();
    idle();
    check("misal_flag",  64'(misaligned),  64'd1);
    check("misal_valid", 64'(trace_valid), 64'd1);
    check("misal_addr",  64'(trace_addr),  64'h6);
    check("misal_data",  64'(trace_data),  64'h77);
    trace_ready = 1'b1;
    tick();
    check("misal_popped", 64'(trace_valid), 64'd0);

    // TOHOST
    trace_ready = 1'b0;
    store(32'h100, 32'h2A);
    tick();
    check("tohost_done",  64'(done),        64'd1);
    check("tohost_exit",  64'(exit_code),   64'h2A);
    check("tohost_valid", 64'(trace_valid), 64'd1);
    check("tohost_addr",  64'(trace_addr),  64'h100);
    check("tohost_data",  64'(trace_data),  64'h2A);
    store(32'h100, 32'h99);
    tick();
    store(32'h4, 32'h11);
    tick();
    idle();
    check("after_done_exit",  64'(exit_code),  64'h2A);
    check("after_done_done",  64'(done),       64'd1);
    check("after_done_drops", 64'(drop_count), 64'd2);
    trace_ready = 1'b1;
    check("after_done_head", 64'(trace_addr), 64'h100);
    tick();
    check("after_done_one_entry", 64'(trace_valid), 64'd0);

    // Plain reset clears done so capture resumes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trace_ready = 1'b0;
    check_flags_clear("reset2");

    // Reset mid-drain with 5 entries held and overflow set
    for (int i = 0; i < 17; i++) begin
      store(32'h4000 + 32'(4 * i), 32'(i));
      tick();
    end
    idle();
    trace_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    trace_ready = 1'b0;
    check("mid_ovf",   64'(overflow),    64'd1);
    check("mid_valid", 64'(trace_valid), 64'd1);
    check("mid_head",  64'(trace_addr),  64'h402C);
    trace_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trace_ready = 1'b0;
    check_flags_clear("mid_reset");
    check("mid_reset_cycle_out", 64'(trace_cycle), 64'd0);
    tick();
    tick();
    store(32'h8, 32'h55);
    tick();
    idle();
    check("post_reset_valid", 64'(trace_valid), 64'd1);
    check("post_reset_cycle", 64'(trace_cycle), 64'd2);
    check("post_reset_addr",  64'(trace_addr),  64'h8);
    check("post_reset_data",  64'(trace_data),  64'h55);
    tick();
    check("post_reset_held", 64'(trace_cycle), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
